// File: rtl/fifo_ro_pkg.sv
// Shared sizing helpers and types for the registered-output FIFO.
package fifo_ro_pkg;

   // Kind of transfer happening at an edge, encoded as {write, read}.
   typedef enum logic [1:0] {
      XFER_NONE = 2'b00,
      XFER_RD   = 2'b01,
      XFER_WR   = 2'b10,
      XFER_BOTH = 2'b11
   } xfer_e;

   // Pointer width: enough bits to address depth words, at least one bit.
   function automatic int ptr_w(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   // Occupancy width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Advance a pointer, wrapping explicitly so non-power-of-two depths work.
   function automatic int unsigned next_ptr(input int unsigned ptr,
                                            input int unsigned depth);
      return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_ro_mem.sv
// Register array for the FIFO: one synchronous write port, one
// asynchronous read port. The read port drives the FIFO head directly.
module fifo_ro_mem
   import fifo_ro_pkg::*;
#(
   parameter int dw    = 16,
   parameter int depth = 8,
   parameter int aw    = ptr_w(depth)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [aw-1:0] wr_addr,
   input  logic [dw-1:0] wr_data,
   input  logic [aw-1:0] rd_addr,
   output logic [dw-1:0] rd_data
);

   logic [dw-1:0] mem [depth];

   // Store the incoming word at the write address on each accepted write.
   // NOTE: storage has no reset on purpose; occupancy guards every read, so
   // stale contents are never observed as valid and the array stays plain flops.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order between processes.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_ro_norm.sv
// Synchronous FIFO with req/ack handshakes on both sides and registered
// output: d_out always comes from storage, never from d_in.
// Optional occupancy output enabled by defining FIFO_RO_COUNT_EN.
// Reset (rstn) is synchronous and active-high despite its name.
module fifo_ro_norm
   import fifo_ro_pkg::*;
#(
   parameter int dw = 16,
   parameter int L  = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [dw-1:0] d_in,
   input  logic          req_in,
   output logic          ack_in,
   output logic [dw-1:0] d_out,
   output logic          req_out,
   input  logic          ack_out
`ifdef FIFO_RO_COUNT_EN
   ,
   output logic [cnt_w(L)-1:0] count
`endif
);

   localparam int PW = ptr_w(L);
   localparam int CW = cnt_w(L);
   localparam logic [CW-1:0] OCC_FULL = CW'(L);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] occ;
   logic [CW-1:0] occ_nxt;
   logic          wr_fire;
   logic          rd_fire;
   xfer_e         xfer;

   // Handshake outputs decode registered occupancy only, so neither side sees
   // a combinational path from the other; a read at full frees space only
   // after the edge.
   assign ack_in  = (occ != OCC_FULL);
   assign req_out = (occ != '0);

   assign wr_fire = req_in & ack_in;
   assign rd_fire = req_out & ack_out;
   assign xfer    = xfer_e'({wr_fire, rd_fire});

   // Next occupancy: count up on write only, down on read only, hold otherwise.
   // NOTE: the default assignment first keeps every path assigned, so no latch
   // is inferred when no case arm matches.
   always_comb begin
      occ_nxt = occ;
      case (xfer)
         XFER_WR: occ_nxt = occ + CW'(1);
         XFER_RD: occ_nxt = occ - CW'(1);
         default: occ_nxt = occ;
      endcase
   end

   // Pointer and occupancy registers; reset wins over any transfer at the edge.
   always_ff @(posedge clk) begin
      if (rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= PW'(next_ptr(32'(wr_ptr), unsigned'(L)));
         end
         if (rd_fire) begin
            rd_ptr <= PW'(next_ptr(32'(rd_ptr), unsigned'(L)));
         end
         occ <= occ_nxt;
      end
   end

   fifo_ro_mem #(
      .dw    (dw),
      .depth (L),
      .aw    (PW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr),
      .wr_data (d_in),
      .rd_addr (rd_ptr),
      .rd_data (d_out)
   );

`ifdef FIFO_RO_COUNT_EN
   assign count = occ;
`endif

endmodule

// File: tb/tb_fifo_ro_norm.sv
// Self-checking bench for fifo_ro_norm: a reference queue tracks every
// accepted word and is compared against the DUT head and handshakes.
module tb_fifo_ro_norm;
   import fifo_ro_pkg::*;

   localparam int DW = 16;
   localparam int L  = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] d_in;
   logic          req_in;
   logic          ack_in;
   logic [DW-1:0] d_out;
   logic          req_out;
   logic          ack_out;
`ifdef FIFO_RO_COUNT_EN
   logic [cnt_w(L)-1:0] count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int words_out     = 0;
   int full_refusals = 0;
   int empty_acks    = 0;

   logic [DW-1:0] model_q [$];

   always #5 clk = ~clk;

   fifo_ro_norm #(.dw(DW), .L(L)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .d_in    (d_in),
      .req_in  (req_in),
      .ack_in  (ack_in),
      .d_out   (d_out),
      .req_out (req_out),
      .ack_out (ack_out)
`ifdef FIFO_RO_COUNT_EN
      ,
      .count   (count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at negedge against the
   // model, then apply the transfers the model expects at the rising edge.
   task automatic cycle(input logic rin, input logic [DW-1:0] din,
                        input logic aout);
      logic exp_ack_in;
      logic exp_req_out;
      req_in  = rin;
      d_in    = din;
      ack_out = aout;
      @(negedge clk);
      exp_ack_in  = (model_q.size() != L);
      exp_req_out = (model_q.size() != 0);
      check("ack_in", 32'(ack_in), 32'(exp_ack_in));
      check("req_out", 32'(req_out), 32'(exp_req_out));
      if (exp_req_out) check("d_out", 32'(d_out), 32'(model_q[0]));
`ifdef FIFO_RO_COUNT_EN
      check("count", 32'(count), 32'(model_q.size()));
`endif
      if (rin && !exp_ack_in) full_refusals++;
      if (aout && !exp_req_out) empty_acks++;
      @(posedge clk);
      if (aout && exp_req_out) begin
         void'(model_q.pop_front());
         words_out++;
      end
      if (rin && exp_ack_in) model_q.push_back(din);
      #1;
   endtask

   // Hold reset for n edges while a producer keeps pushing; all words are lost.
   task automatic do_reset(input int n, input logic rin);
      rstn    = 1'b1;
      req_in  = rin;
      ack_out = 1'b1;
      d_in    = 16'hDEAD;
      repeat (n) @(posedge clk);
      #1;
      rstn = 1'b0;
      model_q.delete();
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] seq;
      int wr_bias;
      int rd_bias;
      rstn = 1'b1; req_in = 1'b0; ack_out = 1'b0; d_in = '0;

      // Reset state.
      do_reset(2, 1'b0);
      cycle(1'b0, '0, 1'b0);

      // Fill to full, then a 9th write must be refused.
      for (int i = 1; i <= L; i++) cycle(1'b1, DW'(i), 1'b0);
      cycle(1'b1, 16'h0009, 1'b0);
      cycle(1'b0, '0, 1'b0);

      // Drain in order, then expect empty.
      for (int i = 0; i < L; i++) cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);

      // Concurrent read/write at occupancy 3 across pointer wrap.
      seq = 16'h0100;
      for (int i = 0; i < 3; i++) begin cycle(1'b1, seq, 1'b0); seq++; end
      for (int i = 0; i < 20; i++) begin cycle(1'b1, seq, 1'b1); seq++; end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

      // Full plus read: read happens, write refused, ack_in back next cycle.
      for (int i = 0; i < L; i++) begin cycle(1'b1, seq, 1'b0); seq++; end
      cycle(1'b1, 16'hBEEF, 1'b1);
      cycle(1'b0, '0, 1'b0);

      // Reset mid-operation discards queued words even with a pending write.
      do_reset(1, 1'b1);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b1, 16'h0A5A, 1'b0);
      cycle(1'b0, '0, 1'b1);

      // Random soak with alternating producer/consumer bias.
      words_out = 0; full_refusals = 0; empty_acks = 0;
      for (int c = 0; c < 10000; c++) begin
         if (((c / 250) % 2) == 0) begin wr_bias = 85; rd_bias = 30; end
         else begin wr_bias = 30; rd_bias = 85; end
         cycle($urandom_range(0, 99) < wr_bias, DW'($urandom),
               $urandom_range(0, 99) < rd_bias);
      end
      check("soak_words>=50", 32'(words_out >= 50), 32'd1);
      check("soak_full_refusals>=5", 32'(full_refusals >= 5), 32'd1);
      check("soak_empty_acks>=5", 32'(empty_acks >= 5), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
